// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - multiplexed 7-segment scan controller with blanking and frame-coherent loads
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   enable              1 = scan digits, 0 = idle with all anodes off
//   load, data_in       one-cycle strobe capturing data_in into the pending register
//   lzb                 blank leading zeros (digit 0 always shown)
//   nibble_out          decoder input, [3:0] = digit of the slot in progress
//   digit_en_n          active-low anode enables, at most one low
//   digit_idx           slot in progress
//   frame_tick          one-cycle pulse on the first blank cycle of digit 0 after a wrap
//   busy                scanner not idle
module display_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 500,
    localparam int IW          = $clog2(NUM_DIGITS),
    localparam int CW          = $clog2(PRESCALE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic                    lzb,
    output logic [7:0]              nibble_out,
    output logic [NUM_DIGITS-1:0]   digit_en_n,
    output logic [IW-1:0]           digit_idx,
    output logic                    frame_tick,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                  state, state_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [IW-1:0]           idx, idx_n;
    logic [4*NUM_DIGITS-1:0] active, active_n;
    logic [4*NUM_DIGITS-1:0] pending;
    logic                    pend_flag, pend_flag_n;
    logic                    wrap;
    logic [3:0]              nib_n;
    logic                    blanked_n;
    logic                    zeros_above;
    logic [NUM_DIGITS-1:0]   en_n_n;

    assign digit_idx = idx;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        idx_n       = idx;
        wrap        = 1'b0;
        active_n    = active;
        pend_flag_n = pend_flag;
        nib_n       = 4'h0;
        blanked_n   = 1'b0;
        zeros_above = 1'b1;
        en_n_n      = '1;

        if (!enable) begin
            state_n = IDLE;
            cnt_n   = '0;
            idx_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = BLANK;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
                BLANK: begin
                    cnt_n = cnt + 1'b1;
                    if (cnt == CW'(BLANK_CYCLES - 1))
                        state_n = SHOW;
                end
                SHOW: begin
                    if (cnt == CW'(PRESCALE - 1)) begin
                        cnt_n   = '0;
                        state_n = BLANK;
                        if (idx == IW'(NUM_DIGITS - 1)) begin
                            idx_n = '0;
                            wrap  = 1'b1;
                        end else begin
                            idx_n = idx + 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
            endcase
        end

        // A load on the wrap edge bypasses pending so it lands in this frame.
        if (wrap) begin
            if (load)
                active_n = data_in;
            else if (pend_flag)
                active_n = pending;
            pend_flag_n = 1'b0;
        end else if (load) begin
            pend_flag_n = 1'b1;
        end

        // Outputs are decoded from next-cycle values so they register in step with the state.
        for (int k = 0; k < NUM_DIGITS; k++)
            if (idx_n == IW'(k))
                nib_n = active_n[4*k +: 4];

        // Walk from the top digit down; digit k is blanked while everything at k and above is zero.
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zeros_above = zeros_above && (active_n[4*k +: 4] == 4'h0);
            if (idx_n == IW'(k) && zeros_above && lzb)
                blanked_n = 1'b1;
        end

        if (state_n == SHOW && !blanked_n)
            for (int k = 0; k < NUM_DIGITS; k++)
                if (idx_n == IW'(k))
                    en_n_n[k] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            active     <= '0;
            pending    <= '0;
            pend_flag  <= 1'b0;
            nibble_out <= 8'h00;
            digit_en_n <= '1;
            frame_tick <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            active     <= active_n;
            pend_flag  <= pend_flag_n;
            if (load)
                pending <= data_in;
            nibble_out <= (state_n == IDLE) ? 8'h00 : {4'h0, nib_n};
            digit_en_n <= en_n_n;
            frame_tick <= wrap;
            busy       <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - directed bench for display_scan_controller
module tb_display_scan_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        load;
    logic [15:0] data_in;
    logic        lzb;
    logic [7:0]  nibble_out;
    logic [3:0]  digit_en_n;
    logic [1:0]  digit_idx;
    logic        frame_tick;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    display_scan_controller #(
        .NUM_DIGITS  (4),
        .PRESCALE    (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .load      (load),
        .data_in   (data_in),
        .lzb       (lzb),
        .nibble_out(nibble_out),
        .digit_en_n(digit_en_n),
        .digit_idx (digit_idx),
        .frame_tick(frame_tick),
        .busy      (busy)
    );

    typedef struct {
        logic [15:0] data;
        logic        lzb;
        logic [15:0] exp_nib;  // slot k expects nibble exp_nib[4k+:4]
        logic [15:0] exp_en;   // slot k expects digit_en_n exp_en[4k+:4] while showing
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_load(input logic [15:0] d);
        @(negedge clk);
        data_in = d;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
    endtask

    task automatic wait_tick(input string tag);
        int n = 0;
        while (frame_tick !== 1'b1 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (frame_tick !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s frame_tick timeout: got 0 expected 1", tag);
        end
    endtask

    // Checks 32 cycles starting on the current (frame_tick) cycle.
    task automatic check_frame(input logic [15:0] exp_nib, input logic [15:0] exp_en, input string tag);
        int s;
        int pos;
        for (int c = 0; c < 32; c++) begin
            if (c > 0) @(negedge clk);
            s   = c / 8;
            pos = c % 8;
            chk($sformatf("%s c%0d tick", tag, c), {31'd0, frame_tick}, {31'd0, c == 0});
            chk($sformatf("%s c%0d idx", tag, c), {30'd0, digit_idx}, s);
            chk($sformatf("%s c%0d nibble", tag, c), {24'd0, nibble_out}, {28'd0, exp_nib[s*4 +: 4]});
            chk($sformatf("%s c%0d en_n", tag, c), {28'd0, digit_en_n},
                (pos < 2) ? 32'hF : {28'd0, exp_en[s*4 +: 4]});
            chk($sformatf("%s c%0d busy", tag, c), {31'd0, busy}, 1);
        end
    endtask

    initial begin
        int n;
        logic [3:0] exp_en;

        vecs[0] = '{16'h12AF, 1'b0, 16'h12AF, 16'h7BDE};
        vecs[1] = '{16'h0005, 1'b1, 16'h0005, 16'hFFFE};
        vecs[2] = '{16'h0005, 1'b0, 16'h0005, 16'h7BDE};
        vecs[3] = '{16'h0000, 1'b1, 16'h0000, 16'hFFFE};
        vecs[4] = '{16'h0A05, 1'b1, 16'h0A05, 16'hFBDE};
        vecs[5] = '{16'h8000, 1'b1, 16'h8000, 16'h7BDE};

        rst = 1'b1; enable = 1'b0; load = 1'b0; data_in = 16'h0; lzb = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset nibble", {24'd0, nibble_out}, 0);
        chk("reset en_n", {28'd0, digit_en_n}, 32'hF);
        chk("reset idx", {30'd0, digit_idx}, 0);
        chk("reset tick", {31'd0, frame_tick}, 0);
        chk("reset busy", {31'd0, busy}, 0);
        rst = 1'b0;
        enable = 1'b1;

        for (int i = 0; i < 6; i++) begin
            lzb = vecs[i].lzb;
            pulse_load(vecs[i].data);
            wait_tick($sformatf("vec%0d", i));
            check_frame(vecs[i].exp_nib, vecs[i].exp_en, $sformatf("vec%0d", i));
        end

        // frame period
        wait_tick("period");
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 64);
        chk("frame period", n, 32);

        // two loads in one frame: last wins, the first never shows
        lzb = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("no tear pre", {31'd0, nibble_out[3:0] == 4'h1}, 0);
        end
        pulse_load(16'h1111);
        repeat (5) begin
            @(negedge clk);
            chk("no tear mid", {31'd0, nibble_out[3:0] == 4'h1}, 0);
        end
        pulse_load(16'h2222);
        n = 0;
        while (frame_tick !== 1'b1 && n < 64) begin
            chk("no tear late", {31'd0, nibble_out[3:0] == 4'h1}, 0);
            @(negedge clk);
            n++;
        end
        check_frame(16'h2222, 16'h7BDE, "last_wins");

        // load on the wrap edge is taken in that frame
        data_in = 16'h3333;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
        check_frame(16'h3333, 16'h7BDE, "wrap_load");

        // drop enable mid-SHOW, load while idle, re-enable
        wait_tick("pre_disable");
        repeat (4) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("disable en_n", {28'd0, digit_en_n}, 32'hF);
        chk("disable busy", {31'd0, busy}, 0);
        chk("disable idx", {30'd0, digit_idx}, 0);
        chk("disable tick", {31'd0, frame_tick}, 0);
        pulse_load(16'h4444);
        chk("idle busy", {31'd0, busy}, 0);
        enable = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            exp_en = (k >= 3 && k <= 8) ? 4'hE : 4'hF;
            chk($sformatf("reen n%0d en_n", k), {28'd0, digit_en_n}, {28'd0, exp_en});
            chk($sformatf("reen n%0d idx", k), {30'd0, digit_idx}, (k <= 8) ? 0 : 1);
            chk($sformatf("reen n%0d busy", k), {31'd0, busy}, 1);
            chk($sformatf("reen n%0d tick", k), {31'd0, frame_tick}, 0);
            chk($sformatf("reen n%0d nibble", k), {24'd0, nibble_out}, 3);
        end
        wait_tick("pending_kept");
        check_frame(16'h4444, 16'h7BDE, "pending_kept");

        // reset during SHOW together with a load
        @(negedge clk);
        repeat (3) @(negedge clk);
        rst     = 1'b1;
        load    = 1'b1;
        data_in = 16'h5555;
        @(negedge clk);
        chk("rst nibble", {24'd0, nibble_out}, 0);
        chk("rst en_n", {28'd0, digit_en_n}, 32'hF);
        chk("rst idx", {30'd0, digit_idx}, 0);
        chk("rst tick", {31'd0, frame_tick}, 0);
        chk("rst busy", {31'd0, busy}, 0);
        rst  = 1'b0;
        load = 1'b0;
        wait_tick("post_rst");
        check_frame(16'h0000, 16'h7BDE, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
